// File: rtl/mul_exec_unit.sv
// mul_exec_unit: iterative RV32M multiply execution unit (MUL/MULH/MULHSU/MULHU).
// Decode issues ops over a valid/ready handshake. The result and destination
// tag are held for writeback until they are taken. A flush kills any op.
// Optional feature macro: MUL_EARLY_OUT_EN (zero/one operand short-cut).
module mul_exec_unit #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 5,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  // Multiplier bits retired per BUSY edge; LATENCY steps cover all WIDTH bits.
  localparam int K  = (WIDTH + LATENCY - 1) / LATENCY;
  // Modulo-2^(2W) accumulation gives the exact 2W-bit product for every op.
  localparam int AW = 2 * WIDTH;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  state_t w_accept_tgt;

  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_out_result;
  logic [TAG_WIDTH-1:0] r_out_tag;

  logic [1:0]           r_op;
  logic [TAG_WIDTH-1:0] r_tag;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_early;
  logic [WIDTH-1:0]     r_early_val;

  logic                 w_accept;
  logic                 w_a_sgn;
  logic                 w_b_neg;
  logic signed [AW-1:0] w_mcand_init;
  logic signed [AW-1:0] w_acc_init;
  logic signed [AW-1:0] w_acc_step;
  logic signed [AW-1:0] w_acc_first;
  logic                 w_busy_done;
  logic [WIDTH-1:0]     w_busy_result;
  logic [WIDTH-1:0]     w_first_result;
  logic                 w_early;
  logic [WIDTH-1:0]     w_early_val;

  // One shift-add step: add the signed multiplicand times a K-bit unsigned slice.
  function automatic logic signed [AW-1:0] step_acc(
    input logic signed [AW-1:0] acc,
    input logic signed [AW-1:0] mcand,
    input logic [K-1:0]         chunk
  );
    logic signed [AW-1:0] chunk_ext;
    chunk_ext = $signed({{(AW-K){1'b0}}, chunk});
    return acc + mcand * chunk_ext;
  endfunction

  // MUL returns the low half of the product; every high variant returns the upper half.
  function automatic logic [WIDTH-1:0] pick_result(
    input logic [1:0]    op,
    input logic [AW-1:0] prod
  );
    return (op == OP_MUL) ? prod[WIDTH-1:0] : prod[AW-1:WIDTH];
  endfunction

  assign in_ready     = reset && !flush &&
                        ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept     = in_valid && in_ready;
  assign w_accept_tgt = (LATENCY == 1) ? S_DONE : S_BUSY;

  // Signedness decides extension: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  // A negative signed rs2 is its unsigned value minus 2^W, so the accumulator
  // starts at -(a << W) and the loop then treats rs2 as unsigned.
  assign w_a_sgn      = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign w_b_neg      = (in_op == OP_MULH) && in_b[WIDTH-1];
  assign w_mcand_init = $signed({{(AW-WIDTH){in_a[WIDTH-1] & w_a_sgn}}, in_a});
  assign w_acc_init   = w_b_neg ? -(w_mcand_init <<< WIDTH) : '0;

  assign w_acc_step     = step_acc(r_acc, r_mcand, r_mplier[K-1:0]);
  assign w_acc_first    = step_acc(w_acc_init, w_mcand_init, in_b[K-1:0]);
  assign w_busy_done    = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_busy_result  = r_early ? r_early_val : pick_result(r_op, w_acc_step);
  assign w_first_result = w_early ? w_early_val : pick_result(in_op, w_acc_first);

`ifdef MUL_EARLY_OUT_EN
  // Detect trivial operands at accept so the op can finish after one edge.
  always_comb begin
    w_early     = 1'b0;
    w_early_val = '0;
    if ((in_a == '0) || (in_b == '0)) begin
      w_early     = 1'b1;
      w_early_val = '0;
    end else if ((in_op == OP_MUL) && (in_a == WIDTH'(1))) begin
      w_early     = 1'b1;
      w_early_val = in_b;
    end else if ((in_op == OP_MUL) && (in_b == WIDTH'(1))) begin
      w_early     = 1'b1;
      w_early_val = in_a;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_val = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and status outputs; flush wins over accept and out_ready.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state == S_BUSY);
    out_valid   = (r_state == S_DONE);
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = w_accept_tgt;
        S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE: if (out_ready) w_state_nxt = w_accept ? w_accept_tgt : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Step counter: loaded at accept, runs down to 0 while BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_early ? '0 : CW'(LATENCY - 1);
    end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result/tag registers: written only on entry to DONE, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (!flush) begin
      if (w_busy_done) begin
        r_out_result <= w_busy_result;
        r_out_tag    <= r_tag;
      end else if ((LATENCY == 1) && w_accept) begin
        r_out_result <= w_first_result;
        r_out_tag    <= in_tag;
      end
    end
  end

  // Operand latch and shift-add datapath; inputs are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op        <= in_op;
      r_tag       <= in_tag;
      r_acc       <= w_acc_init;
      r_mcand     <= w_mcand_init;
      r_mplier    <= in_b;
      r_early     <= w_early;
      r_early_val <= w_early_val;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand <<< K;
      r_mplier <= r_mplier >> K;
    end
  end

  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Testbench for mul_exec_unit (WIDTH=32, LATENCY=5, TAG_WIDTH=5).
module tb_mul_exec_unit;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  mul_exec_unit #(.WIDTH(32), .LATENCY(5), .TAG_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference product from full-width signed arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sbv, p;
    sa  = (op == MULH || op == MULHSU) ? {{34{a[31]}}, a} : {34'b0, a};
    sbv = (op == MULH) ? {{34{b[31]}}, b} : {34'b0, b};
    p   = sa * sbv;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit trivial;
    trivial = (a == 0) || (b == 0) || ((op == MUL) && ((a == 1) || (b == 1)));
    return (EARLY && trivial) ? 1 : 5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output bit ok);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  // Wait for out_valid after an accept, check latency and the scoreboard head.
  task automatic wait_check(input int lat, input string nm);
    int   n = 0;
    exp_t e;
    for (int i = 1; i <= lat + 10; i++) begin
      tick();
      if (out_valid) begin n = i; break; end
    end
    vectors++;
    if (n != lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges, required %0d", nm, n, lat);
    end
    if (n == 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: output with empty queue, result %h", nm, out_result);
      return;
    end
    e = sb.pop_front();
    if (out_result !== e.res) begin
      miscompares++;
      $display("FAIL %s_result: got %h, required %h", nm, out_result, e.res);
    end
    vectors++;
    if (out_tag !== e.tag) begin
      miscompares++;
      $display("FAIL %s_tag: got %0d, required %0d", nm, out_tag, e.tag);
    end
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_consume: out_valid %b, required 0", nm, out_valid);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] expv, input string nm);
    bit ok;
    issue(op, a, b, tag, ok);
    if (!ok) return;
    sb.push_back('{expv, tag});
    wait_check(exp_lat(op, a, b), nm);
    consume(nm);
  endtask

  task automatic test_reset();
    bit ok;
    bit stale;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_status: out_valid %b busy %b, required 0 0", out_valid, busy);
    end
    vectors++;
    if (out_result !== 32'h0 || out_tag !== 5'h0) begin
      miscompares++;
      $display("FAIL rst_data: result %h tag %0d, required 0 0", out_result, out_tag);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_ready: got %b, required 0", in_ready);
    end
    tick(); tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_ready: got %b, required 1", in_ready);
    end
    run_op(MUL, 32'd5, 32'd6, 5'd7, 32'd30, "pre_reset");
    // Reset lands in the middle of a BUSY op.
    issue(MUL, 32'd9, 32'd9, 5'd2, ok);
    tick(); tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: busy %b, required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst_ctrl: valid %b busy %b ready %b, required 0 0 0", out_valid, busy, in_ready);
    end
    vectors++;
    if (out_result !== 32'h0 || out_tag !== 5'h0) begin
      miscompares++;
      $display("FAIL async_rst_data: result %h tag %0d, required 0 0", out_result, out_tag);
    end
    tick();
    reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    vectors++;
    if (stale || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst: stale valid %b ready %b, required 0 1", stale, in_ready);
    end
  endtask

  task automatic test_latency_hold();
    bit ok;
    issue(MUL, 32'd2, 32'd1, 5'd3, ok);
    if (!ok) return;
    sb.push_back('{32'h00000002, 5'd3});
    wait_check(exp_lat(MUL, 32'd2, 32'd1), "lat_mul");
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 32'h2 || out_tag !== 5'd3) begin
        miscompares++;
        $display("FAIL hold_%0d: valid %b result %h tag %0d, required 1 00000002 3", i, out_valid, out_result, out_tag);
      end
    end
    consume("lat_mul");
  endtask

  task automatic test_ops();
    logic [31:0] a, b;
    logic [1:0]  op;
    run_op(MUL,    32'hFFFFFFFE, 32'h3, 5'd1, 32'hFFFFFFFA, "mul_neg");
    run_op(MULH,   32'hFFFFFFFE, 32'h3, 5'd2, 32'hFFFFFFFF, "mulh_neg");
    run_op(MULHU,  32'hFFFFFFFE, 32'h3, 5'd3, 32'h00000002, "mulhu_neg");
    run_op(MULHSU, 32'hFFFFFFFE, 32'h3, 5'd4, 32'hFFFFFFFF, "mulhsu_neg");
    run_op(MULH,   32'h80000000, 32'h80000000, 5'd5, 32'h40000000, "mulh_min");
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, "mulhu_max");
    run_op(MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'h80000000, "mulhsu_edge");
    run_op(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'h00000001, "mul_max");
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'(i % 4);
      run_op(op, a, b, 5'(i + 10), model(op, a, b), "rand");
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    int   n = 0;
    exp_t e;
    issue(MUL, 32'd3, 32'd4, 5'd4, ok);
    if (!ok) return;
    sb.push_back('{32'd12, 5'd4});
    // Op B waits on the input while A computes; the consumer is always ready.
    in_op = MULHU; in_a = 32'h80000000; in_b = 32'd4; in_tag = 5'd5; in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (out_valid) begin n = i; break; end
    end
    vectors++;
    if (n != 5 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_a_timing: edges %0d ready %b, required 5 1", n, in_ready);
    end
    e = sb.pop_front();
    vectors++;
    if (out_result !== e.res || out_tag !== e.tag) begin
      miscompares++;
      $display("FAIL b2b_a_result: got %h/%0d, required %h/%0d", out_result, out_tag, e.res, e.tag);
    end
    sb.push_back('{32'h00000002, 5'd5});
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: valid %b busy %b, required 0 1", out_valid, busy);
    end
    wait_check(5, "b2b_b");
    consume("b2b_b");
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    issue(MUL, 32'd5, 32'd6, 5'd9, ok);
    tick(); tick();
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b, required 0", in_ready);
    end
    tick();
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy: busy %b valid %b, required 0 0", busy, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_discard: out_valid rose %b, required 0", seen);
    end
    run_op(MUL, 32'd2, 32'd1, 5'd11, 32'd2, "after_flush");
    // Flush a completed result that the consumer has not taken.
    issue(MUL, 32'd7, 32'd9, 5'd6, ok);
    if (!ok) return;
    sb.push_back('{32'd63, 5'd6});
    wait_check(5, "flush_done_op");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_early();
    run_op(MUL,  32'h1234, 32'h0, 5'd12, 32'h0, "early_zero");
    run_op(MUL,  32'h1,    32'h7, 5'd13, 32'h7, "early_one");
    run_op(MULH, 32'h0,    32'hFFFFFFFF, 5'd14, 32'h0, "early_mulh_zero");
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_latency_hold();
    test_ops();
    test_back_to_back();
    test_flush();
    test_early();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
